// File: rtl/port_out_scheduler_if.sv
// Read-side handshake bundle between one output port's scheduler and the
// cache manager / read datapath. The scheduler uses the master view; the
// cache manager (or a bench) uses the slave view.
//
// Handshake rules:
// - rd_req rises with a registered rd_priority.
// - rd_req and rd_priority hold steady until a one-cycle rd_grant pulse.
// - rd_req drops the cycle after the grant.
// - pkt_done pulses once, with the eop word of the granted packet, strictly
//   after the grant cycle.
// - busy covers the whole span from request to pkt_done.
interface port_out_scheduler_if #(
    parameter int num_of_priorities = 8,
    parameter int priority_width    = 3,
    parameter int wrr_weight_width  = 4
) ();
    logic                                          sp0_wrr1;
    logic [num_of_priorities-1:0]                  prepared;
    logic [num_of_priorities-1:0]                  ready;
    logic [num_of_priorities*wrr_weight_width-1:0] wrr_weight;
    logic                                          rd_req;
    logic [priority_width-1:0]                     rd_priority;
    logic                                          rd_grant;
    logic                                          pkt_done;
    logic                                          busy;
    // Debug view of the scheduler FSM: 0 = IDLE, 1 = REQ, 2 = XFER.
    logic [1:0]                                    fsm_state;

    modport master (
        input  sp0_wrr1, prepared, ready, wrr_weight, rd_grant, pkt_done,
        output rd_req, rd_priority, busy, fsm_state
    );

    modport slave (
        output sp0_wrr1, prepared, ready, wrr_weight, rd_grant, pkt_done,
        input  rd_req, rd_priority, busy, fsm_state
    );
endinterface

// File: rtl/port_out_scheduler.sv
// Per-output-port packet scheduler. Picks one of the port's priority queues
// by strict priority or weighted round robin, issues one read request to the
// cache manager, and holds the choice until the packet's eop has left.
module port_out_scheduler #(
    parameter int num_of_priorities = 8,
    parameter int priority_width    = 3,
    parameter int wrr_weight_width  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    port_out_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                        state;
    logic [wrr_weight_width-1:0]   credit [num_of_priorities];
    logic [priority_width-1:0]     rr_ptr;
    logic                          served_wrr;

    logic [num_of_priorities-1:0]  eligible;
    logic [num_of_priorities-1:0]  cand;
    logic [num_of_priorities-1:0]  wrr_cand;
    logic                          reload;
    logic [wrr_weight_width-1:0]   eff_weight [num_of_priorities];
    logic [priority_width-1:0]     sp_sel;
    logic [priority_width-1:0]     wrr_sel;
    logic                          wrr_found;
    logic [priority_width-1:0]     idx;

    assign bus.fsm_state = state;

    // Decision logic for the IDLE cycle: eligibility, effective weights,
    // credit candidates and both selection results.
    always_comb begin
        eligible  = bus.prepared & bus.ready;
        cand      = '0;
        sp_sel    = '0;
        wrr_sel   = '0;
        wrr_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < num_of_priorities; i++) begin
            eff_weight[i] = bus.wrr_weight[i*wrr_weight_width +: wrr_weight_width];
            if (eff_weight[i] == '0) begin
                eff_weight[i] = wrr_weight_width'(1);
            end
            cand[i] = eligible[i] && (credit[i] != '0);
            // Ascending scan so the highest eligible index is the last one kept.
            if (eligible[i]) begin
                sp_sel = priority_width'(i);
            end
        end
        // With no credited candidates every eligible queue is credited again by
        // the reload, and effective weights are never zero.
        reload   = (cand == '0) && (eligible != '0);
        wrr_cand = reload ? eligible : cand;
        // Descending search from rr_ptr; the index wraps naturally at 3 bits.
        for (int k = 0; k < num_of_priorities; k++) begin
            idx = rr_ptr - priority_width'(k);
            if (!wrr_found && wrr_cand[idx]) begin
                wrr_sel   = idx;
                wrr_found = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered request outputs and WRR bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bus.rd_req      <= 1'b0;
            bus.rd_priority <= '0;
            bus.busy        <= 1'b0;
            rr_ptr          <= priority_width'(num_of_priorities - 1);
            served_wrr      <= 1'b0;
            for (int i = 0; i < num_of_priorities; i++) begin
                credit[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        state      <= REQ;
                        bus.rd_req <= 1'b1;
                        bus.busy   <= 1'b1;
                        served_wrr <= bus.sp0_wrr1;
                        if (bus.sp0_wrr1) begin
                            bus.rd_priority <= wrr_sel;
                            rr_ptr          <= wrr_sel;
                            if (reload) begin
                                for (int i = 0; i < num_of_priorities; i++) begin
                                    credit[i] <= eff_weight[i];
                                end
                            end
                        end else begin
                            bus.rd_priority <= sp_sel;
                        end
                    end
                end
                REQ: begin
                    // The request is held regardless of prepared/ready changes.
                    if (bus.rd_grant) begin
                        bus.rd_req <= 1'b0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (bus.pkt_done) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        if (served_wrr) begin
                            if (credit[bus.rd_priority] > wrr_weight_width'(1)) begin
                                credit[bus.rd_priority] <= credit[bus.rd_priority] - wrr_weight_width'(1);
                            end else begin
                                credit[bus.rd_priority] <= '0;
                                rr_ptr <= bus.rd_priority - priority_width'(1);
                            end
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.rd_req <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_port_out_scheduler.sv
// Bench for port_out_scheduler: hand-written latency / hold / reset sequences
// followed by a table of packets whose expected queue choices feed a
// scoreboard queue.
module tb_port_out_scheduler;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam int WW = 4;
    localparam int NV = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    port_out_scheduler_if #(.num_of_priorities(N), .priority_width(PW), .wrr_weight_width(WW)) bus ();

    port_out_scheduler #(.num_of_priorities(N), .priority_width(PW), .wrr_weight_width(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rst_first;
        logic          mode;
        logic [N-1:0]  prep;
        logic [N-1:0]  rdy;
        logic [N*WW-1:0] wts;
        logic [PW-1:0] exp_pri;
    } vec_t;

    vec_t            vecs [NV];
    logic [PW-1:0]   exp_q [$];
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Waits for a request, compares against the scoreboard, grants it and
    // finishes the packet done_delay cycles after the grant.
    task automatic serve_packet(input int done_delay);
        logic [PW-1:0] exp_pri;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.rd_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        exp_pri = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (!bus.rd_req) begin
            check("req_timeout", 32'(bus.rd_req), 32'd1);
            return;
        end
        check("sb_rd_priority", 32'(bus.rd_priority), 32'(exp_pri));
        check("sb_busy_in_req", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 bus.rd_grant = 1'b1;
        @(posedge clk);
        #1 bus.rd_grant = 1'b0;
        repeat (done_delay - 1) @(posedge clk);
        #1 bus.pkt_done = 1'b1;
        @(posedge clk);
        #1 bus.pkt_done = 1'b0;
        check("sb_busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // SP basic, then ready[5] dropped.
        for (int i = 0; i < 4; i++) vecs[i] = '{1'b0, 1'b0, 8'h29, 8'hFF, 32'h0, 3'd5};
        for (int i = 4; i < 6; i++) vecs[i] = '{1'b0, 1'b0, 8'h29, 8'hDF, 32'h0, 3'd3};
        // WRR order with w7=2, w3=1.
        vecs[6]  = '{1'b1, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd7};
        vecs[7]  = '{1'b0, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd7};
        vecs[8]  = '{1'b0, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd3};
        vecs[9]  = '{1'b0, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd7};
        vecs[10] = '{1'b0, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd7};
        vecs[11] = '{1'b0, 1'b1, 8'h88, 8'hFF, 32'h2000_1000, 3'd3};
        // WRR all-zero weights, then ready[1] dropped after a 4.
        vecs[12] = '{1'b1, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd4};
        vecs[13] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd1};
        vecs[14] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd0};
        vecs[15] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd4};
        vecs[16] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd1};
        vecs[17] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd0};
        vecs[18] = '{1'b0, 1'b1, 8'h13, 8'hFF, 32'h0, 3'd4};
        vecs[19] = '{1'b0, 1'b1, 8'h13, 8'hFD, 32'h0, 3'd0};
        vecs[20] = '{1'b0, 1'b1, 8'h13, 8'hFD, 32'h0, 3'd4};
        vecs[21] = '{1'b0, 1'b1, 8'h13, 8'hFD, 32'h0, 3'd0};

        bus.sp0_wrr1   = 1'b0;
        bus.prepared   = '0;
        bus.ready      = 8'hFF;
        bus.wrr_weight = '0;
        bus.rd_grant   = 1'b0;
        bus.pkt_done   = 1'b0;

        // Reset values while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rd_priority", 32'(bus.rd_priority), 32'd0);
        check("rst_state", 32'(bus.fsm_state), 32'd0);
        rst = 1'b1;

        // SP latency: eligible seen at N, request at N+1, drop at M+1,
        // busy low at K+1, next request at K+2.
        @(posedge clk);
        #1 bus.prepared = 8'h01;
        @(negedge clk);
        check("lat_req_at_n", 32'(bus.rd_req), 32'd0);
        @(posedge clk);
        #1;
        check("lat_req_at_n1", 32'(bus.rd_req), 32'd1);
        check("lat_pri", 32'(bus.rd_priority), 32'd0);
        check("lat_busy", 32'(bus.busy), 32'd1);
        bus.rd_grant = 1'b1;
        @(posedge clk);
        #1 bus.rd_grant = 1'b0;
        check("lat_req_m1", 32'(bus.rd_req), 32'd0);
        check("lat_busy_xfer", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 bus.pkt_done = 1'b1;
        @(posedge clk);
        #1 bus.pkt_done = 1'b0;
        check("lat_busy_k1", 32'(bus.busy), 32'd0);
        check("lat_req_k1", 32'(bus.rd_req), 32'd0);
        @(posedge clk);
        #1;
        check("lat_req_k2", 32'(bus.rd_req), 32'd1);

        // Stray pkt_done in REQ, then pkt_done coinciding with the grant.
        bus.pkt_done = 1'b1;
        @(posedge clk);
        #1 bus.pkt_done = 1'b0;
        check("done_in_req_state", 32'(bus.fsm_state), 32'd1);
        check("done_in_req_req", 32'(bus.rd_req), 32'd1);
        bus.rd_grant = 1'b1;
        bus.pkt_done = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_grant = 1'b0;
        bus.pkt_done = 1'b0;
        bus.prepared = '0;
        check("same_cycle_state", 32'(bus.fsm_state), 32'd2);
        @(posedge clk);
        #1;
        check("same_cycle_busy", 32'(bus.busy), 32'd1);
        bus.pkt_done = 1'b1;
        @(posedge clk);
        #1 bus.pkt_done = 1'b0;
        check("same_cycle_end_busy", 32'(bus.busy), 32'd0);
        bus.rd_grant = 1'b1;
        @(posedge clk);
        #1 bus.rd_grant = 1'b0;
        @(posedge clk);
        #1;
        check("grant_in_idle_state", 32'(bus.fsm_state), 32'd0);
        check("grant_in_idle_req", 32'(bus.rd_req), 32'd0);

        // Request hold with grant withheld and eligibility removed.
        bus.prepared = 8'h04;
        @(posedge clk);
        #1;
        check("hold_req_rise", 32'(bus.rd_req), 32'd1);
        bus.prepared = '0;
        bus.ready    = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_rd_req", 32'(bus.rd_req), 32'd1);
            check("hold_rd_priority", 32'(bus.rd_priority), 32'd2);
        end
        @(posedge clk);
        #1;
        bus.ready    = 8'hFF;
        bus.rd_grant = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_grant = 1'b0;
        bus.pkt_done = 1'b1;
        @(posedge clk);
        #1 bus.pkt_done = 1'b0;
        check("hold_end_state", 32'(bus.fsm_state), 32'd0);
        check("hold_end_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of XFER, then a quiet idle.
        bus.prepared = 8'h40;
        @(posedge clk);
        #1;
        check("mid_rst_pri", 32'(bus.rd_priority), 32'd6);
        bus.rd_grant = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_grant = 1'b0;
        bus.prepared = '0;
        @(negedge clk);
        check("mid_rst_in_xfer", 32'(bus.fsm_state), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rd_priority", 32'(bus.rd_priority), 32'd0);
        check("mid_rst_state", 32'(bus.fsm_state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_no_req", 32'(bus.rd_req), 32'd0);
        end

        // Table of packets through the scoreboard.
        @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].rst_first) do_reset();
            bus.sp0_wrr1   = vecs[v].mode;
            bus.prepared   = vecs[v].prep;
            bus.ready      = vecs[v].rdy;
            bus.wrr_weight = vecs[v].wts;
            exp_q.push_back(vecs[v].exp_pri);
            serve_packet(4);
        end
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
